dzcpu_uop_sequencer: RTL and testbench

DZCPU_UOP_SEQUENCER -- requirements
Module: dzcpu_uop_sequencer

---
 rtl/dzcpu_uop_sequencer.sv | 98 +++++++++
 tb/tb_dzcpu_uop_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu_uop_sequencer: microcode sequencer that fetches an opcode (and an optional
// CB-prefix byte), maps it to a uop ROM flow and steps through that flow.
//   iClock, iReset_n      : clock, asynchronous active-low reset
//   iMop, iMopValid       : opcode/prefix byte from memory and its valid strobe
//   iFlowIdx, iCbFlowIdx  : main / CB-prefix LUT start addresses for oMop
//   iUopFlow, iJcb        : flow-control field and jcb flag of the current uop
//   iFlagZ, iStall        : datapath Z flag, datapath/memory wait
//   oUopAddr, oMop        : uop ROM address, latched opcode byte
//   oFetch, oUopValid     : byte request, uop executes this cycle
//   oPcInc, oFlagsWe, oEof: PC increment, flag write, end-of-flow strobes
//   oTrap                 : CB flow index 0 trapped (only with DZCPU_USEQ_CB_TRAP_EN)
// Optional feature macro: DZCPU_USEQ_CB_TRAP_EN
module dzcpu_uop_sequencer (
  input  logic       iClock,
  input  logic       iReset_n,
  input  logic [7:0] iMop,
  input  logic       iMopValid,
  input  logic [7:0] iFlowIdx,
  input  logic [7:0] iCbFlowIdx,
  input  logic [3:0] iUopFlow,
  input  logic       iJcb,
  input  logic       iFlagZ,
  input  logic       iStall,
  output logic [7:0] oUopAddr,
  output logic [7:0] oMop,
  output logic       oFetch,
  output logic       oUopValid,
  output logic       oPcInc,
  output logic       oFlagsWe,
  output logic       oEof,
  output logic       oTrap
);
  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, CB_FETCH, CB_DECODE
`ifdef DZCPU_USEQ_CB_TRAP_EN
    , TRAP
`endif
  } state_t;
  state_t state, state_n;
  logic [7:0] addr_n, mop_n;
  logic run, ends;
  assign run = state == EXEC && !iStall;
  // Codes 6/7 end the flow conditionally on Z; codes 9-15 fall through as plain OP.
  assign ends = (iUopFlow inside {[4'd2:4'd5]}) || (iUopFlow == 4'd6 && iFlagZ) ||
                (iUopFlow == 4'd7 && !iFlagZ);
`ifdef DZCPU_USEQ_CB_TRAP_EN
  assign oTrap = state == TRAP;
`else
  assign oTrap = 1'b0;
`endif
  always_ff @(posedge iClock or negedge iReset_n)
    if (!iReset_n) begin
      state    <= FETCH;
      oUopAddr <= '0;
      oMop     <= '0;
    end else begin
      state    <= state_n;
      oUopAddr <= addr_n;
      oMop     <= mop_n;
    end
  always_comb begin
    state_n   = state;
    addr_n    = oUopAddr;
    mop_n     = oMop;
    oFetch    = state == FETCH || state == CB_FETCH;
    oUopValid = run;
    oPcInc    = run && (iUopFlow inside {4'd1, 4'd3, 4'd5, 4'd6, 4'd7});
    oFlagsWe  = run && (iUopFlow inside {4'd4, 4'd5, 4'd8});
    // jcb wins over any end condition carried by the same uop.
    oEof      = run && !iJcb && ends;
    case (state)
      FETCH, CB_FETCH: if (iMopValid) begin
        mop_n   = iMop;
        state_n = state == FETCH ? DECODE : CB_DECODE;
      end
      DECODE: begin
        addr_n  = iFlowIdx;
        state_n = EXEC;
      end
      EXEC: if (run) begin
        state_n = iJcb ? CB_FETCH : oEof ? FETCH : EXEC;
        addr_n  = iJcb ? oUopAddr : oEof ? 8'd0 : oUopAddr + 8'd1;
      end
`ifdef DZCPU_USEQ_CB_TRAP_EN
      CB_DECODE: begin
        addr_n  = iCbFlowIdx == 8'd0 ? oUopAddr : iCbFlowIdx;
        state_n = iCbFlowIdx == 8'd0 ? TRAP : EXEC;
      end
`else
      CB_DECODE: begin
        addr_n  = iCbFlowIdx;
        state_n = EXEC;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// tb_dzcpu_uop_sequencer: scoreboard bench; a uop ROM / opcode LUT model feeds the
// DUT, each issued instruction is expanded into its expected uop list up front, and
// a monitor pops one entry per executed uop.
module tb_dzcpu_uop_sequencer;
  logic       iClock = 0, iReset_n = 0;
  logic [7:0] iMop = 0;
  logic       iMopValid = 0, iStall = 0;
  logic [7:0] iFlowIdx, iCbFlowIdx;
  logic [3:0] iUopFlow;
  logic       iJcb, iFlagZ;
  logic [7:0] oUopAddr, oMop;
  logic       oFetch, oUopValid, oPcInc, oFlagsWe, oEof, oTrap;

  logic [3:0] rom_flow [256];
  logic       rom_jcb  [256];
  logic       rom_z    [256];
  logic [7:0] lut      [256];
  logic [7:0] cblut    [256];

  typedef struct packed {logic [7:0] a; logic [7:0] m; logic inc; logic fu; logic eof;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] bytes_q[$];
  int total = 0, passed = 0;

  assign iUopFlow   = rom_flow[oUopAddr];
  assign iJcb       = rom_jcb[oUopAddr];
  assign iFlagZ     = rom_z[oUopAddr];
  assign iFlowIdx   = lut[oMop];
  assign iCbFlowIdx = cblut[oMop];

  dzcpu_uop_sequencer dut (
    .iClock(iClock), .iReset_n(iReset_n), .iMop(iMop), .iMopValid(iMopValid),
    .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx), .iUopFlow(iUopFlow), .iJcb(iJcb),
    .iFlagZ(iFlagZ), .iStall(iStall), .oUopAddr(oUopAddr), .oMop(oMop), .oFetch(oFetch),
    .oUopValid(oUopValid), .oPcInc(oPcInc), .oFlagsWe(oFlagsWe), .oEof(oEof), .oTrap(oTrap)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  function automatic exp_t e(input int a, input int m, input int inc, input int fu, input int eof);
    return '{8'(a), 8'(m), inc[0], fu[0], eof[0]};
  endfunction

  // Expand one instruction into its uop list from the flow-code rules.
  task automatic issue(input logic [7:0] op, input logic [7:0] cb);
    logic [7:0] a, m;
    logic [3:0] f;
    logic d;
    bytes_q.push_back(op);
    m = op;
    a = lut[op];
    for (int n = 0; n < 64; n++) begin
      f = rom_flow[a];
      d = (f inside {[4'd2:4'd5]}) || (f == 4'd6 && rom_z[a]) || (f == 4'd7 && !rom_z[a]);
      exp_q.push_back('{a, m, f inside {4'd1, 4'd3, 4'd5, 4'd6, 4'd7}, f inside {4'd4, 4'd5, 4'd8},
                        d && !rom_jcb[a]});
      if (rom_jcb[a]) begin
        bytes_q.push_back(cb);
        m = cb;
        a = cblut[cb];
      end else if (d) break;
      else a = a + 8'd1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    for (int n = 0; n < 50 && !oFetch; n++) tick();
    if (!oFetch) chk("send_wait_fetch", {31'd0, oFetch}, 32'd1);
    iMopValid = 1;
    iMop = b;
    tick();
    iMopValid = 0;
    iMop = 8'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    for (n = 0; n < 100 && !(exp_q.size() == 0 && oFetch); n++) tick();
    chk(name, {exp_q.size() == 0, oFetch}, 32'd3);
  endtask

  always @(negedge iClock) if (iReset_n) begin
    if (iStall) chk("stall_quiet", {oUopValid, oPcInc, oFlagsWe, oEof}, 32'd0);
    if (oUopValid) begin
      if (exp_q.size() == 0) chk("unexpected_uop", {oUopAddr, oMop}, 32'hFFFFFFFF);
      else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("uop{addr,mop,inc,fwe,eof}", {oUopAddr, oMop, oPcInc, oFlagsWe, oEof}, 32'(x));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom_flow[i] = 4'($urandom_range(0, 15));
      rom_z[i]    = 1'($urandom_range(0, 1));
      rom_jcb[i]  = i >= 64 && i < 128 && $urandom_range(0, 7) == 0;
      if (i % 8 == 7) begin rom_flow[i] = 4'd2; rom_jcb[i] = 0; end
      if (i < 64) rom_jcb[i] = 0;
      lut[i]   = 8'($urandom);
      cblut[i] = 8'($urandom_range(128, 255));
    end
    lut[8'h31] = 1;
    rom_flow[1] = 1; rom_flow[2] = 0; rom_flow[3] = 1; rom_flow[4] = 3;
    lut[8'h40] = 19; rom_flow[19] = 6; rom_z[19] = 1; rom_flow[20] = 2;
    lut[8'h41] = 15; rom_flow[15] = 3; rom_jcb[15] = 1; cblut[8'h7C] = 16; rom_flow[16] = 2;
    lut[8'h42] = 56; rom_flow[56] = 0; rom_flow[57] = 2;
    lut[8'h43] = 100; rom_flow[100] = 0; rom_flow[101] = 0;
    lut[8'h44] = 24; rom_flow[24] = 1; rom_jcb[24] = 1; cblut[8'h00] = 0; rom_flow[0] = 2;
    #3;
    chk("reset_regs", {oUopAddr, oMop, 7'd0, oTrap}, 32'd0);
    chk("reset_comb", {oFetch, oUopValid, oPcInc, oFlagsWe, oEof}, 32'b10000);
    tick();
    iReset_n = 1;

    exp_q.push_back(e(1, 'h31, 1, 0, 0)); exp_q.push_back(e(2, 'h31, 0, 0, 0));
    exp_q.push_back(e(3, 'h31, 1, 0, 0)); exp_q.push_back(e(4, 'h31, 1, 0, 1));
    send(8'h31);
    chk("lat_decode_idle", {31'd0, oUopValid}, 32'd0);
    tick();
    chk("lat_first_uop", {oUopValid, oUopAddr}, {23'd0, 1'b1, 8'd1});
    drain("flow_1013_done");

    exp_q.push_back(e(19, 'h40, 1, 0, 1));
    send(8'h40);
    drain("z_eof_done");
    chk("z_eof_addr0", oUopAddr, 32'd0);
    rom_z[19] = 0;
    exp_q.push_back(e(19, 'h40, 1, 0, 0)); exp_q.push_back(e(20, 'h40, 0, 0, 1));
    send(8'h40);
    drain("nz_cont_done");

    exp_q.push_back(e(15, 'h41, 1, 0, 0)); exp_q.push_back(e(16, 'h7C, 0, 0, 1));
    send(8'h41);
    tick();
    tick();
    chk("jcb_cb_fetch", {oFetch, oUopValid}, 32'b10);
    send(8'h7C);
    tick();
    chk("cb_first_uop", {oUopValid, oUopAddr}, {23'd0, 1'b1, 8'd16});
    drain("cb_done");

    exp_q.push_back(e(56, 'h42, 0, 0, 0)); exp_q.push_back(e(57, 'h42, 0, 0, 1));
    send(8'h42);
    iStall = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", {oUopAddr, oUopValid, oPcInc}, {22'd0, 8'd56, 2'b00});
      if (i < 2) tick();
    end
    iStall = 0;
    drain("stall_resume_done");

    exp_q.push_back(e(100, 'h43, 0, 0, 0));
    send(8'h43);
    tick();
    @(negedge iClock);
    #2;
    iReset_n = 0;
    #1;
    chk("abort_reset", {oUopAddr, oFetch, oEof, oPcInc, oUopValid}, {20'd0, 8'd0, 4'b1000});
    tick();
    iReset_n = 1;
    chk("abort_queue", exp_q.size(), 32'd0);

    exp_q.push_back(e(24, 'h44, 1, 0, 0));
`ifndef DZCPU_USEQ_CB_TRAP_EN
    exp_q.push_back(e(0, 'h00, 0, 0, 1));
`endif
    send(8'h44);
    tick();
    tick();
    send(8'h00);
    tick();
`ifdef DZCPU_USEQ_CB_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      iMopValid = 1;
      iMop = 8'($urandom);
      chk("trap_hold", {oTrap, oFetch, oUopValid}, 32'b100);
      tick();
    end
    iMopValid = 0;
`else
    chk("cb0_exec", {oTrap, oUopValid, oUopAddr}, {22'd0, 2'b01, 8'd0});
`endif
    drain("cb0_done");
    iReset_n = 0;
    #1;
    chk("trap_cleared", {oTrap, oFetch}, 32'b01);
    tick();
    iReset_n = 1;

    for (int k = 0; k < 40; k++) issue(8'($urandom), 8'($urandom_range(1, 255)));
    for (int c = 0; c < 20000 && (bytes_q.size() != 0 || exp_q.size() != 0); c++) begin
      iStall = $urandom_range(0, 4) == 0;
      if (oFetch) begin
        iMopValid = bytes_q.size() != 0 && $urandom_range(0, 3) != 0;
        iMop = iMopValid ? bytes_q.pop_front() : 8'($urandom);
      end else begin
        iMopValid = $urandom_range(0, 2) == 0;
        iMop = 8'($urandom);
      end
      tick();
    end
    iStall = 0;
    iMopValid = 0;
    tick();
    chk("random_drained", {bytes_q.size() == 0, exp_q.size() == 0, oFetch}, 32'b111);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
